// File: rtl/spi_master.sv
// SPI mode-0 master: one full-duplex DATA_W-bit word per start pulse, MSB first.
// Every SCK, SS and MOSI transition lands on a multiple of CLK_DIV clk cycles
// after the accepting edge, so the bus timing is fixed for a given parameter set.
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              ss,
  output logic              sck,
  output logic              mosi,
  input  logic              miso
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ss_q, ss_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;

  logic                div_wrap;
  logic [DIV_W-1:0]    div_next;
  logic [DATA_W-1:0]   rx_shifted;
  logic [DATA_W-1:0]   tx_shifted;

  assign div_wrap   = (div_cnt_q == DIV_LAST);
  assign div_next   = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
  assign rx_shifted = DATA_W'({rx_sr_q, miso});
  assign tx_shifted = tx_sr_q << 1;

  // Next-state and datapath; the SETUP->SHIFT hand-over itself is the first (rising) SCK edge.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    dout_d     = dout_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ss_d       = ss_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SETUP;
          tx_sr_d    = din;
          mosi_d     = din[DATA_W-1];
          ss_d       = 1'b0;
          busy_d     = 1'b1;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
        end
      end

      S_SETUP: begin
        div_cnt_d = div_next;
        if (div_wrap) begin
          state_d    = S_SHIFT;
          sck_d      = 1'b1;
          rx_sr_d    = rx_shifted;
          edge_cnt_d = EDGE_W'(1);
        end
      end

      S_SHIFT: begin
        div_cnt_d = div_next;
        if (div_wrap) begin
          sck_d      = ~sck_q;
          edge_cnt_d = edge_cnt_q + EDGE_W'(1);
          if (!sck_q) begin
            rx_sr_d = rx_shifted;
          end else if (edge_cnt_q == EDGE_LAST) begin
            state_d = S_HOLD;
          end else begin
            tx_sr_d = tx_shifted;
            mosi_d  = tx_shifted[DATA_W-1];
          end
        end
      end

      S_HOLD: begin
        div_cnt_d = div_next;
        if (div_wrap) begin
          state_d = S_GAP;
          ss_d    = 1'b1;
        end
      end

      S_GAP: begin
        div_cnt_d = div_next;
        if (div_wrap) begin
          state_d = S_IDLE;
          dout_d  = rx_sr_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over any request on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      dout_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ss_q       <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ss_q       <= ss_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ss   = ss_q;
  assign sck  = sck_q;
  assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: loopback, slave model, randomized words,
// ignored start while busy, mid-transfer reset, back-to-back and CLK_DIV=1.
module tb_spi_master;

  localparam int DW = 8;
  localparam int CD = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          busy;
  logic          done;
  logic          ss;
  logic          sck;
  logic          mosi;
  logic          miso;

  logic          start1;
  logic [DW-1:0] din1;
  logic [DW-1:0] dout1;
  logic          busy1;
  logic          done1;
  logic          ss1;
  logic          sck1;
  logic          mosi1;
  logic          miso1;

  logic          loop_mode;
  logic [DW-1:0] slave_word;
  logic          slave_bit;
  int            slave_idx;

  int checks;
  int errors;

  int       pulse_at;
  logic [DW-1:0] pulse_din;
  int       obs_done_n;
  int       obs_done_cnt;
  int       obs_ss_rise_n;
  int       obs_ss_refall;
  int       obs_rise_cnt;
  logic     obs_ss_at0;
  logic     obs_busy_at0;
  logic [DW-1:0] obs_dout;
  logic     obs_busy_done;
  logic     obs_mosi_done;
  logic [DW-1:0] obs_mosi_word;

  spi_master #(.DATA_W(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .dout(dout), .busy(busy),
    .done(done), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso)
  );

  spi_master #(.DATA_W(DW), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .din(din1), .dout(dout1), .busy(busy1),
    .done(done1), .ss(ss1), .sck(sck1), .mosi(mosi1), .miso(miso1)
  );

  assign miso  = loop_mode ? mosi : slave_bit;
  assign miso1 = mosi1;

  // Free-running system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model: presents its word MSB first from ss fall, advancing after each falling SCK.
  always @(negedge ss) begin
    slave_idx = DW - 1;
    slave_bit = slave_word[DW-1];
  end

  // Slave model shift on falling SCK while selected.
  always @(negedge sck) begin
    if (ss === 1'b0 && slave_idx > 0) begin
      slave_idx = slave_idx - 1;
      slave_bit = slave_word[slave_idx];
    end
  end

  // Reference timing from the bus rules: k-th SCK edge at k*CD after E0.
  function automatic int exp_done_n(input int dw, input int cd);
    return (2 * dw + 2) * cd;
  endfunction

  function automatic int exp_ss_rise_n(input int dw, input int cd);
    return (2 * dw + 1) * cd;
  endfunction

  task automatic launch(input logic [DW-1:0] v);
    @(posedge clk); #1;
    start = 1'b1;
    din   = v;
    @(posedge clk); #1;
    start = 1'b0;
    din   = DW'($urandom);
  endtask

  task automatic observe(input int ncycles);
    logic prev_sck;
    logic seen_rise;
    obs_done_n    = -1;
    obs_done_cnt  = 0;
    obs_ss_rise_n = -1;
    obs_ss_refall = 0;
    obs_rise_cnt  = 0;
    obs_mosi_word = '0;
    obs_dout      = 'x;
    obs_busy_done = 1'bx;
    obs_mosi_done = 1'bx;
    obs_ss_at0    = ss;
    obs_busy_at0  = busy;
    prev_sck      = sck;
    seen_rise     = 1'b0;
    for (int n = 1; n <= ncycles; n++) begin
      if (n == pulse_at) begin
        start = 1'b1;
        din   = pulse_din;
      end
      if (n == pulse_at + 1) start = 1'b0;
      @(posedge clk); #1;
      if (sck === 1'b1 && prev_sck === 1'b0) begin
        obs_rise_cnt++;
        obs_mosi_word = {obs_mosi_word[DW-2:0], mosi};
      end
      if (ss === 1'b1 && obs_ss_rise_n < 0) begin
        obs_ss_rise_n = n;
        seen_rise = 1'b1;
      end
      if (seen_rise && ss !== 1'b1) obs_ss_refall++;
      if (done === 1'b1) begin
        obs_done_cnt++;
        if (obs_done_n < 0) begin
          obs_done_n    = n;
          obs_dout      = dout;
          obs_busy_done = busy;
          obs_mosi_done = mosi;
        end
      end
      prev_sck = sck;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ss, sck, mosi, busy, done} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got ss,sck,mosi,busy,done=%b expected %b", {ss, sck, mosi, busy, done}, 5'b10000);
    end
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_dout: got %h expected %h", dout, 8'h00);
    end
    checks++;
    if ({ss1, sck1, mosi1, busy1, done1, dout1} !== {5'b10000, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_dut1: got %b expected %b", {ss1, sck1, mosi1, busy1, done1, dout1}, {5'b10000, 8'h00});
    end
    rst = 1'b0;
  endtask

  task automatic test_loopback;
    loop_mode = 1'b1;
    launch(8'hA5);
    observe(exp_done_n(DW, CD) + 10);
    checks++;
    if (obs_ss_at0 !== 1'b0 || obs_busy_at0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL loopback_e0: got ss=%b busy=%b expected ss=0 busy=1", obs_ss_at0, obs_busy_at0);
    end
    checks++;
    if (obs_ss_rise_n !== exp_ss_rise_n(DW, CD)) begin
      errors++;
      $display("[TB] FAIL loopback_ss_rise: got E0+%0d expected E0+%0d", obs_ss_rise_n, exp_ss_rise_n(DW, CD));
    end
    checks++;
    if (obs_done_n !== exp_done_n(DW, CD)) begin
      errors++;
      $display("[TB] FAIL loopback_done_time: got E0+%0d expected E0+%0d", obs_done_n, exp_done_n(DW, CD));
    end
    checks++;
    if (obs_done_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL loopback_done_width: got %0d cycles expected 1", obs_done_cnt);
    end
    checks++;
    if (obs_rise_cnt !== DW) begin
      errors++;
      $display("[TB] FAIL loopback_rises: got %0d expected %0d", obs_rise_cnt, DW);
    end
    checks++;
    if (obs_dout !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL loopback_dout: got %h expected %h", obs_dout, 8'hA5);
    end
    checks++;
    if (obs_busy_done !== 1'b0 || obs_mosi_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL loopback_done_state: got busy=%b mosi=%b expected 0 0", obs_busy_done, obs_mosi_done);
    end
  endtask

  task automatic test_slave;
    loop_mode  = 1'b0;
    slave_word = 8'h3C;
    launch(8'hC3);
    observe(exp_done_n(DW, CD) + 10);
    checks++;
    if (obs_mosi_word !== 8'hC3 || obs_rise_cnt !== DW) begin
      errors++;
      $display("[TB] FAIL slave_mosi_bits: got %b (%0d rises) expected %b", obs_mosi_word, obs_rise_cnt, 8'hC3);
    end
    checks++;
    if (obs_dout !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL slave_dout: got %h expected %h", obs_dout, 8'h3C);
    end
  endtask

  task automatic test_random;
    logic [DW-1:0] tx;
    logic [DW-1:0] sw;
    logic [DW-1:0] exp;
    logic          lm;
    for (int it = 0; it < 4; it++) begin
      lm         = 1'($urandom_range(0, 1));
      tx         = DW'($urandom);
      sw         = DW'($urandom);
      loop_mode  = lm;
      slave_word = sw;
      exp        = lm ? tx : sw;
      launch(tx);
      observe(exp_done_n(DW, CD) + 4);
      checks++;
      if (obs_dout !== exp) begin
        errors++;
        $display("[TB] FAIL random_dout[%0d]: got %h expected %h", it, obs_dout, exp);
      end
      checks++;
      if (obs_mosi_word !== tx || obs_done_n !== exp_done_n(DW, CD)) begin
        errors++;
        $display("[TB] FAIL random_bus[%0d]: got mosi=%h done=E0+%0d expected mosi=%h done=E0+%0d",
                 it, obs_mosi_word, obs_done_n, tx, exp_done_n(DW, CD));
      end
    end
  endtask

  task automatic test_ignore_busy;
    loop_mode = 1'b1;
    pulse_at  = 20;
    pulse_din = 8'hFF;
    launch(8'h12);
    observe(exp_done_n(DW, CD) + 30);
    pulse_at = -1;
    checks++;
    if (obs_rise_cnt !== DW || obs_done_cnt !== 1 || obs_ss_refall !== 0) begin
      errors++;
      $display("[TB] FAIL ignore_busy_single: got rises=%0d dones=%0d refall=%0d expected %0d 1 0",
               obs_rise_cnt, obs_done_cnt, obs_ss_refall, DW);
    end
    checks++;
    if (obs_dout !== 8'h12) begin
      errors++;
      $display("[TB] FAIL ignore_busy_dout: got %h expected %h", obs_dout, 8'h12);
    end
  endtask

  task automatic test_reset_mid;
    int late_done;
    int late_ss_low;
    loop_mode = 1'b1;
    launch(8'h33);
    for (int n = 1; n <= 29; n++) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({ss, sck, mosi, busy, done} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_mid_ctrl: got ss,sck,mosi,busy,done=%b expected %b", {ss, sck, mosi, busy, done}, 5'b10000);
    end
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mid_dout: got %h expected %h", dout, 8'h00);
    end
    late_done   = 0;
    late_ss_low = 0;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) late_done++;
      if (ss !== 1'b1) late_ss_low++;
    end
    checks++;
    if (late_done !== 0 || late_ss_low !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_quiet: got dones=%0d ss_low=%0d expected 0 0", late_done, late_ss_low);
    end
    launch(8'h5A);
    observe(exp_done_n(DW, CD) + 4);
    checks++;
    if (obs_dout !== 8'h5A || obs_done_n !== exp_done_n(DW, CD)) begin
      errors++;
      $display("[TB] FAIL reset_mid_recover: got dout=%h done=E0+%0d expected %h E0+%0d",
               obs_dout, obs_done_n, 8'h5A, exp_done_n(DW, CD));
    end
  endtask

  task automatic test_back_to_back;
    int first_done;
    int second_fall;
    int second_done;
    int ss_high_cnt;
    logic seen_rise;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    loop_mode   = 1'b1;
    first_done  = -1;
    second_fall = -1;
    second_done = -1;
    ss_high_cnt = 0;
    seen_rise   = 1'b0;
    d1 = 'x;
    d2 = 'x;
    @(posedge clk); #1;
    start = 1'b1;
    din   = 8'h81;
    @(posedge clk); #1;
    din = 8'h7E;
    for (int n = 1; n <= 200 && second_done < 0; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (first_done < 0) begin
          first_done = n;
          d1 = dout;
        end else begin
          second_done = n;
          d2 = dout;
        end
      end
      if (ss === 1'b1) seen_rise = 1'b1;
      if (seen_rise && second_fall < 0) begin
        if (ss === 1'b1) ss_high_cnt++;
        else begin
          second_fall = n;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (first_done !== exp_done_n(DW, CD) || d1 !== 8'h81) begin
      errors++;
      $display("[TB] FAIL b2b_first: got done=E0+%0d dout=%h expected E0+%0d %h", first_done, d1, exp_done_n(DW, CD), 8'h81);
    end
    checks++;
    if (second_fall !== exp_done_n(DW, CD) + 1) begin
      errors++;
      $display("[TB] FAIL b2b_second_ss_fall: got E0+%0d expected E0+%0d", second_fall, exp_done_n(DW, CD) + 1);
    end
    checks++;
    if (!(ss_high_cnt >= CD)) begin
      errors++;
      $display("[TB] FAIL b2b_ss_gap: got %0d cycles expected at least %0d", ss_high_cnt, CD);
    end
    checks++;
    if (second_done !== 2 * exp_done_n(DW, CD) + 1 || d2 !== 8'h7E) begin
      errors++;
      $display("[TB] FAIL b2b_second: got done=E0+%0d dout=%h expected E0+%0d %h",
               second_done, d2, 2 * exp_done_n(DW, CD) + 1, 8'h7E);
    end
  endtask

  task automatic test_clk_div1;
    int sck_ok;
    int done_n;
    logic [DW-1:0] d;
    sck_ok = 0;
    done_n = -1;
    d = 'x;
    @(posedge clk); #1;
    start1 = 1'b1;
    din1   = 8'h96;
    @(posedge clk); #1;
    start1 = 1'b0;
    din1   = DW'($urandom);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n <= 2 * DW && sck1 === n[0]) sck_ok++;
      if (done1 === 1'b1 && done_n < 0) begin
        done_n = n;
        d = dout1;
      end
    end
    checks++;
    if (sck_ok !== 2 * DW) begin
      errors++;
      $display("[TB] FAIL div1_sck_toggle: got %0d matching cycles expected %0d", sck_ok, 2 * DW);
    end
    checks++;
    if (done_n !== exp_done_n(DW, 1)) begin
      errors++;
      $display("[TB] FAIL div1_done_time: got E0+%0d expected E0+%0d", done_n, exp_done_n(DW, 1));
    end
    checks++;
    if (d !== 8'h96) begin
      errors++;
      $display("[TB] FAIL div1_dout: got %h expected %h", d, 8'h96);
    end
  endtask

  // Test sequence.
  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    din        = '0;
    start1     = 1'b0;
    din1       = '0;
    loop_mode  = 1'b1;
    slave_word = '0;
    slave_bit  = 1'b0;
    slave_idx  = 0;
    pulse_at   = -1;
    pulse_din  = '0;
    test_reset();
    test_loopback();
    test_slave();
    test_random();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_clk_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
